// File: rtl/mips_data_mem.sv
// Data-memory responder: word RAM with WAIT_CYCLES stall cycles plus a zero-wait MMIO window (CYCLE/LED/STATUS).
// RAM accesses stall the core via mem_stall until DONE; MMIO and faulting accesses complete in the issue cycle.
module mips_data_mem #(
  parameter int          ADDR_WIDTH  = 10,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dout,
  output logic [31:0] mem_din,
  output logic        mem_stall,
  output logic        addr_err,
  output logic [15:0] led
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] rd_q;
  logic [31:0] cycle_q, cycle_d;
  logic [15:0] led_q, led_d;
  logic        err_q, err_d;

  logic [31:0] ram [0:(1<<ADDR_WIDTH)-1];

  logic                  req, misal, hit_ram, hit_mmio, in_idle;
  logic                  ram_req, mmio_req, bad_req, mmio_wr, mmio_rd, ram_we;
  logic [1:0]            reg_off;
  logic [ADDR_WIDTH-1:0] idx;

  // Requests are ignored while reset is held so the outputs stay quiet.
  assign req      = rst & (mem_ren | mem_wen);
  assign misal    = (mem_addr[1:0] != 2'b00);
  assign hit_ram  = (mem_addr[31:ADDR_WIDTH+2] == '0);
  assign hit_mmio = (mem_addr[31:4] == MMIO_BASE[31:4]);
  assign in_idle  = (state_q == S_IDLE);
  assign ram_req  = req & in_idle & ~misal & hit_ram;
  assign mmio_req = req & in_idle & ~misal & hit_mmio;
  assign bad_req  = req & in_idle & (misal | (~hit_ram & ~hit_mmio));
  assign mmio_wr  = mmio_req & mem_wen;
  assign mmio_rd  = mmio_req & ~mem_wen;
  assign reg_off  = mem_addr[3:2];
  assign idx      = mem_addr[ADDR_WIDTH+1:2];
  assign ram_we   = (state_q == S_DONE) & mem_wen;

  assign mem_stall = ram_req | (state_q == S_WAIT);
  assign addr_err  = err_q;
  assign led       = led_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rd_q    <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          rd_q <= ram[idx];
          if (ram_req) begin
            cnt_q   <= CNT_INIT;
            state_q <= (CNT_INIT == 4'd0) ? S_DONE : S_WAIT;
          end
        end
        S_WAIT: begin
          rd_q  <= ram[idx];
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= S_DONE;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // No reset on the array: contents survive reset, and a write only commits out of DONE.
  always_ff @(posedge clk) begin
    if (ram_we) ram[idx] <= mem_dout;
  end

  always_comb begin
    cycle_d = cycle_q + 32'd1;
    led_d   = led_q;
    err_d   = err_q | bad_req;
    if (mmio_wr) begin
      case (reg_off)
        2'd0:    cycle_d = mem_dout;
        2'd1:    led_d   = mem_dout[15:0];
        2'd2:    if (mem_dout[0]) err_d = 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_q <= 32'd0;
      led_q   <= 16'd0;
      err_q   <= 1'b0;
    end else begin
      cycle_q <= cycle_d;
      led_q   <= led_d;
      err_q   <= err_d;
    end
  end

  // Read data is only driven in the cycle a read actually completes.
  always_comb begin
    mem_din = 32'd0;
    if (state_q == S_DONE && mem_ren && !mem_wen) begin
      mem_din = rd_q;
    end else if (mmio_rd) begin
      case (reg_off)
        2'd0:    mem_din = cycle_q;
        2'd1:    mem_din = {16'd0, led_q};
        2'd2:    mem_din = {31'd0, err_q};
        default: mem_din = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_data_mem.sv
// Bench for mips_data_mem: directed scenarios plus a randomized mix checked against a transaction-level model.
module tb_mips_data_mem;
  localparam int          W  = 2;
  localparam logic [31:0] MB = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_ren = 1'b0;
  logic        mem_wen = 1'b0;
  logic [31:0] mem_addr = 32'd0;
  logic [31:0] mem_dout = 32'd0;
  logic [31:0] mem_din;
  logic        mem_stall;
  logic        addr_err;
  logic [15:0] led;

  int checks = 0;
  int errors = 0;
  int tb_cyc = 0;

  logic [31:0] ram_m [int];
  logic [15:0] led_m = 16'd0;
  logic        err_m = 1'b0;

  mips_data_mem #(.ADDR_WIDTH(10), .WAIT_CYCLES(W), .MMIO_BASE(MB)) dut (
    .clk(clk), .rst(rst), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_din(mem_din),
    .mem_stall(mem_stall), .addr_err(addr_err), .led(led)
  );

  always #5 clk = ~clk;
  always @(posedge clk) tb_cyc++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Called just after a rising edge; returns just after the edge that ends the access.
  task automatic access(input logic wen, input logic ren, input logic [31:0] addr,
                        input logic [31:0] wdat, output int stalls,
                        output logic [31:0] rdata, output logic din_bad);
    bit done = 0;
    mem_wen = wen; mem_ren = ren; mem_addr = addr; mem_dout = wdat;
    stalls = 0; rdata = 32'd0; din_bad = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (mem_stall === 1'b1) begin
        stalls++;
        if (mem_din !== 32'd0) din_bad = 1'b1;
        @(posedge clk); #1;
      end else begin
        rdata = mem_din;
        done = 1;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL access_timeout addr %h still stalled after 40 cycles", addr);
    end
    @(posedge clk); #1;
    mem_wen = 1'b0; mem_ren = 1'b0;
  endtask

  task automatic test_reset();
    int st; logic [31:0] rd; logic bad;
    rst = 1'b0; mem_ren = 1'b1; mem_addr = 32'h10;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %b exp 0", mem_stall); end
    checks++; if (mem_din !== 32'd0) begin errors++; $display("FAIL rst_din got %h exp 0", mem_din); end
    checks++; if (led !== 16'd0) begin errors++; $display("FAIL rst_led got %h exp 0", led); end
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", addr_err); end
    mem_ren = 1'b0; rst = 1'b1; led_m = 16'd0; err_m = 1'b0;
    access(1'b0, 1'b1, MB, 32'd0, st, rd, bad);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL rst_cycle0 got %h exp 0", rd); end
  endtask

  task automatic test_ram_basic();
    int st; logic [31:0] rd; logic bad;
    access(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, st, rd, bad);
    ram_m[4] = 32'hDEADBEEF;
    checks++; if (st !== W) begin errors++; $display("FAIL wr_stall got %0d exp %0d", st, W); end
    checks++; if (rd !== 32'd0 || bad !== 1'b0) begin errors++; $display("FAIL wr_din got %h bad %b exp 0", rd, bad); end
    access(1'b0, 1'b1, 32'h10, 32'd0, st, rd, bad);
    checks++; if (st !== W) begin errors++; $display("FAIL rd_stall got %0d exp %0d", st, W); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got %h exp deadbeef", rd); end
  endtask

  task automatic test_back_to_back();
    int st0, st1, st2, st3, t0; logic [31:0] r0, r1, rx, v0, v1; logic bad;
    v0 = $urandom; v1 = $urandom;
    t0 = tb_cyc;
    access(1'b1, 1'b0, 32'h0, v0, st0, rx, bad);
    access(1'b1, 1'b0, 32'h4, v1, st1, rx, bad);
    access(1'b0, 1'b1, 32'h0, 32'd0, st2, r0, bad);
    access(1'b0, 1'b1, 32'h4, 32'd0, st3, r1, bad);
    ram_m[0] = v0; ram_m[1] = v1;
    checks++; if (st0 !== W || st1 !== W || st2 !== W || st3 !== W) begin errors++;
      $display("FAIL b2b_stall got %0d %0d %0d %0d exp %0d", st0, st1, st2, st3, W); end
    checks++; if (tb_cyc - t0 !== 4 * (W + 1)) begin errors++; $display("FAIL b2b_cycles got %0d exp %0d", tb_cyc - t0, 4 * (W + 1)); end
    checks++; if (r0 !== v0) begin errors++; $display("FAIL b2b_rd0 got %h exp %h", r0, v0); end
    checks++; if (r1 !== v1) begin errors++; $display("FAIL b2b_rd1 got %h exp %h", r1, v1); end
  endtask

  task automatic test_cycle();
    int st; logic [31:0] c0, c1, v, rd; logic bad; int k;
    access(1'b0, 1'b1, MB, 32'd0, st, c0, bad);
    repeat (4) @(posedge clk);
    #1;
    access(1'b0, 1'b1, MB, 32'd0, st, c1, bad);
    checks++; if (c1 - c0 !== 32'd5) begin errors++; $display("FAIL cycle_delta got %0d exp 5", c1 - c0); end
    checks++; if (st !== 0) begin errors++; $display("FAIL cycle_stall got %0d exp 0", st); end
    for (int n = 0; n < 4; n++) begin
      v = (n == 0) ? 32'hFFFF_FFFE : $urandom;
      k = (n == 0) ? 2 : $urandom_range(0, 6);
      access(1'b1, 1'b0, MB, v, st, rd, bad);
      repeat (k) @(posedge clk);
      #1;
      access(1'b0, 1'b1, MB, 32'd0, st, rd, bad);
      checks++; if (rd !== v + 32'(k)) begin errors++; $display("FAIL cycle_load got %h exp %h", rd, v + 32'(k)); end
    end
  endtask

  task automatic test_led();
    int st; logic [31:0] rd; logic bad;
    access(1'b1, 1'b0, MB + 32'h4, 32'h1234_ABCD, st, rd, bad);
    led_m = 16'hABCD;
    checks++; if (st !== 0) begin errors++; $display("FAIL led_stall got %0d exp 0", st); end
    checks++; if (led !== 16'hABCD) begin errors++; $display("FAIL led_out got %h exp abcd", led); end
    access(1'b0, 1'b1, MB + 32'h4, 32'd0, st, rd, bad);
    checks++; if (rd !== 32'h0000_ABCD) begin errors++; $display("FAIL led_rd got %h exp 0000abcd", rd); end
  endtask

  task automatic test_errors();
    int st; logic [31:0] rd; logic bad;
    access(1'b0, 1'b1, 32'h2, 32'd0, st, rd, bad);
    checks++; if (st !== 0 || rd !== 32'd0) begin errors++; $display("FAIL misal_rd stall %0d din %h exp 0 0", st, rd); end
    checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL misal_err got %b exp 1", addr_err); end
    access(1'b1, 1'b0, 32'h8000_0000, 32'h5A5A_5A5A, st, rd, bad);
    checks++; if (st !== 0) begin errors++; $display("FAIL unmap_stall got %0d exp 0", st); end
    access(1'b1, 1'b0, 32'h11, 32'h0BAD_0BAD, st, rd, bad);
    access(1'b0, 1'b1, 32'h10, 32'd0, st, rd, bad);
    checks++; if (rd !== ram_m[4]) begin errors++; $display("FAIL misal_noram got %h exp %h", rd, ram_m[4]); end
    access(1'b0, 1'b1, MB + 32'h8, 32'd0, st, rd, bad);
    checks++; if (rd !== 32'd1) begin errors++; $display("FAIL status_rd got %h exp 1", rd); end
    access(1'b1, 1'b0, MB + 32'h8, 32'd1, st, rd, bad);
    err_m = 1'b0;
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL status_clr got %b exp 0", addr_err); end
    access(1'b0, 1'b1, MB + 32'hC, 32'd0, st, rd, bad);
    checks++; if (rd !== 32'd0 || addr_err !== 1'b0) begin errors++; $display("FAIL off_c din %h err %b exp 0 0", rd, addr_err); end
  endtask

  task automatic test_random();
    int st, exp_st, w, kind; logic [31:0] rd, exp_rd, a, d; logic bad, wr, rdn;
    for (int i = 0; i < 64; i++) begin
      d = $urandom;
      access(1'b1, 1'b0, 32'(i) << 2, d, st, rd, bad);
      ram_m[i] = d;
    end
    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 7);
      w = $urandom_range(0, 63);
      d = $urandom;
      wr = 1'b0; rdn = 1'b1; exp_st = 0; exp_rd = 32'd0;
      case (kind)
        0, 1, 2: begin
          wr = 1'($urandom_range(0, 1)); rdn = wr ? 1'($urandom_range(0, 1)) : 1'b1;
          a = 32'(w) << 2; exp_st = W;
          if (wr) ram_m[w] = d; else exp_rd = ram_m[w];
        end
        3: begin wr = 1'b1; rdn = 1'b0; a = MB + 32'h4; led_m = d[15:0]; end
        4: begin a = MB + 32'h4; exp_rd = {16'd0, led_m}; end
        5: begin
          wr = 1'($urandom_range(0, 1)); rdn = ~wr;
          a = (w[0]) ? ((32'(w) << 2) | 32'($urandom_range(1, 3)))
                     : (32'h4000_0000 | ($urandom & 32'h0FFF_FFFC));
          err_m = 1'b1;
        end
        6: begin a = MB + 32'h8; exp_rd = {31'd0, err_m}; end
        default: begin wr = 1'b1; rdn = 1'b0; a = MB + 32'h8; if (d[0]) err_m = 1'b0; end
      endcase
      access(wr, rdn, a, d, st, rd, bad);
      checks++; if (st !== exp_st) begin errors++; $display("FAIL rnd_stall op %0d addr %h got %0d exp %0d", n, a, st, exp_st); end
      checks++; if (rd !== exp_rd || bad !== 1'b0) begin errors++; $display("FAIL rnd_din op %0d addr %h got %h exp %h", n, a, rd, exp_rd); end
      checks++; if (addr_err !== err_m) begin errors++; $display("FAIL rnd_err op %0d got %b exp %b", n, addr_err, err_m); end
      checks++; if (led !== led_m) begin errors++; $display("FAIL rnd_led op %0d got %h exp %h", n, led, led_m); end
    end
  endtask

  task automatic test_async_reset();
    int st; logic [31:0] rd; logic bad;
    access(1'b1, 1'b0, 32'h20, 32'hA5A5_0001, st, rd, bad);
    ram_m[8] = 32'hA5A5_0001;
    access(1'b1, 1'b0, MB + 32'h4, 32'h0000_00FF, st, rd, bad);
    mem_wen = 1'b1; mem_addr = 32'h20; mem_dout = 32'h55;
    @(posedge clk); #1;
    checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL arst_pre_stall got %b exp 1", mem_stall); end
    rst = 1'b0;
    #1;
    checks++; if (mem_stall !== 1'b0 || mem_din !== 32'd0) begin errors++;
      $display("FAIL arst_outs stall %b din %h exp 0 0", mem_stall, mem_din); end
    checks++; if (led !== 16'd0 || addr_err !== 1'b0) begin errors++; $display("FAIL arst_regs led %h err %b exp 0 0", led, addr_err); end
    repeat (3) @(posedge clk);
    #1;
    mem_wen = 1'b0; rst = 1'b1; led_m = 16'd0; err_m = 1'b0;
    access(1'b0, 1'b1, MB, 32'd0, st, rd, bad);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL arst_cycle got %h exp 0", rd); end
    access(1'b0, 1'b1, MB + 32'h4, 32'd0, st, rd, bad);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL arst_led got %h exp 0", rd); end
    access(1'b0, 1'b1, 32'h20, 32'd0, st, rd, bad);
    checks++; if (rd !== ram_m[8]) begin errors++; $display("FAIL arst_ram got %h exp %h", rd, ram_m[8]); end
  endtask

  initial begin
    test_reset();
    test_ram_basic();
    test_back_to_back();
    test_cycle();
    test_led();
    test_errors();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
